// File: rtl/seven_seg_pkg.sv
// Shared definitions for the seven-segment capture block: FSM state
// encoding, segment pattern constants (gfedcba, active-high), the default
// multiplexer strobe period and the pattern-to-hex decode function.
package seven_seg_pkg;

  localparam int unsigned FREQ_DEFAULT = 40000;
  localparam int unsigned SEG_W        = 7;
  localparam int unsigned NIB_W        = 4;
  localparam int unsigned PAIR_W       = 2 * SEG_W;
  localparam int unsigned WD_MIN_W     = 18;

  typedef enum logic {
    WAIT_HI = 1'b0,
    WAIT_LO = 1'b1
  } state_t;

  typedef struct packed {
    logic             known;
    logic [NIB_W-1:0] nibble;
  } digit_t;

  localparam logic [SEG_W-1:0] SEG_0 = 7'h3F;
  localparam logic [SEG_W-1:0] SEG_1 = 7'h06;
  localparam logic [SEG_W-1:0] SEG_2 = 7'h5B;
  localparam logic [SEG_W-1:0] SEG_3 = 7'h4F;
  localparam logic [SEG_W-1:0] SEG_4 = 7'h66;
  localparam logic [SEG_W-1:0] SEG_5 = 7'h6D;
  localparam logic [SEG_W-1:0] SEG_6 = 7'h7D;
  localparam logic [SEG_W-1:0] SEG_7 = 7'h07;
  localparam logic [SEG_W-1:0] SEG_8 = 7'h7F;
  localparam logic [SEG_W-1:0] SEG_9 = 7'h6F;
  localparam logic [SEG_W-1:0] SEG_A = 7'h77;
  localparam logic [SEG_W-1:0] SEG_B = 7'h7C;
  localparam logic [SEG_W-1:0] SEG_C = 7'h39;
  localparam logic [SEG_W-1:0] SEG_D = 7'h5E;
  localparam logic [SEG_W-1:0] SEG_E = 7'h79;
  localparam logic [SEG_W-1:0] SEG_F = 7'h71;

  // Unrecognised patterns (blank included) decode to nibble 0, known 0.
  function automatic digit_t seg_decode(input logic [SEG_W-1:0] pattern);
    digit_t d;
    d.known  = 1'b1;
    d.nibble = 4'h0;
    case (pattern)
      SEG_0:   d.nibble = 4'h0;
      SEG_1:   d.nibble = 4'h1;
      SEG_2:   d.nibble = 4'h2;
      SEG_3:   d.nibble = 4'h3;
      SEG_4:   d.nibble = 4'h4;
      SEG_5:   d.nibble = 4'h5;
      SEG_6:   d.nibble = 4'h6;
      SEG_7:   d.nibble = 4'h7;
      SEG_8:   d.nibble = 4'h8;
      SEG_9:   d.nibble = 4'h9;
      SEG_A:   d.nibble = 4'hA;
      SEG_B:   d.nibble = 4'hB;
      SEG_C:   d.nibble = 4'hC;
      SEG_D:   d.nibble = 4'hD;
      SEG_E:   d.nibble = 4'hE;
      SEG_F:   d.nibble = 4'hF;
      default: d.known  = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/seven_seg_decode.sv
// Combinational decode of one seven-segment pattern into a hex nibble.
// Ports: pattern (gfedcba) in; nibble_c, known_c out (combinational).
module seven_seg_decode
  import seven_seg_pkg::*;
(
  input  logic [SEG_W-1:0] pattern,
  output logic [NIB_W-1:0] nibble_c,
  output logic             known_c
);

  digit_t dig_c;

  always_comb begin
    dig_c    = seg_decode(pattern);
    nibble_c = dig_c.nibble;
    known_c  = dig_c.known;
  end

endmodule

// File: rtl/seven_seg_capture.sv
// Reconstructs a hi/lo digit pair from a strobed, multiplexed seven-segment
// bus and watches the strobe for a stale link.
// Ports: clk, rst (sync, active-high); segment[6:0], sig (strobe) in;
//        both7seg[13:7]=hi, [6:0]=lo; pair_valid pulse; hi/lo_nibble and
//        hi/lo_known decode; locked; timeout (sticky until next strobe).
// Build option: define SEVEN_SEG_DECODE_EN to enable the hex decode;
// otherwise the nibble/known outputs read 0.
module seven_seg_capture
  import seven_seg_pkg::*;
#(
  parameter int unsigned FREQ    = FREQ_DEFAULT,
  parameter int unsigned TIMEOUT = 2 * (FREQ + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [SEG_W-1:0]  segment,
  input  logic              sig,
  output logic [PAIR_W-1:0] both7seg,
  output logic              pair_valid,
  output logic [NIB_W-1:0]  hi_nibble,
  output logic [NIB_W-1:0]  lo_nibble,
  output logic              hi_known,
  output logic              lo_known,
  output logic              locked,
  output logic              timeout
);

  localparam int unsigned TO_BITS = $clog2(TIMEOUT + 1);
  localparam int unsigned WD_W    = (TO_BITS > WD_MIN_W) ? TO_BITS : WD_MIN_W;
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT);

  state_t              state_q, state_d;
  logic [WD_W-1:0]     wd_q, wd_d;
  logic [PAIR_W-1:0]   word_q, word_d;
  logic                pv_q, pv_d;
  logic                locked_q, locked_d;
  logic                to_q, to_d;

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= WAIT_HI;
      wd_q     <= '0;
      word_q   <= '0;
      pv_q     <= 1'b0;
      locked_q <= 1'b0;
      to_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      wd_q     <= wd_d;
      word_q   <= word_d;
      pv_q     <= pv_d;
      locked_q <= locked_d;
      to_q     <= to_d;
    end
  end

  // Next state: a strobe always wins over the watchdog expiring.
  always_comb begin
    state_d  = state_q;
    wd_d     = wd_q;
    word_d   = word_q;
    pv_d     = 1'b0;
    locked_d = locked_q;
    to_d     = to_q;
    if (sig) begin
      wd_d = '0;
      to_d = 1'b0;
      if (state_q == WAIT_HI) begin
        word_d[PAIR_W-1:SEG_W] = segment;
        state_d                = WAIT_LO;
      end else begin
        word_d[SEG_W-1:0] = segment;
        pv_d              = 1'b1;
        locked_d          = 1'b1;
        state_d           = WAIT_HI;
      end
    end else begin
      if (wd_q != WD_MAX) begin
        wd_d = wd_q + WD_W'(1);
      end
      // Stale link: drop lock and resynchronise on the next strobe as hi.
      if (wd_d == WD_MAX) begin
        to_d     = 1'b1;
        locked_d = 1'b0;
        state_d  = WAIT_HI;
      end
    end
  end

  assign both7seg   = word_q;
  assign pair_valid = pv_q;
  assign locked     = locked_q;
  assign timeout    = to_q;

  // Decoders read the stored fields so the nibbles track both7seg exactly;
  // a blank pattern decodes to 0/unknown, which ties the outputs off.
  logic [SEG_W-1:0] hi_pat, lo_pat;
`ifdef SEVEN_SEG_DECODE_EN
  assign hi_pat = word_q[PAIR_W-1:SEG_W];
  assign lo_pat = word_q[SEG_W-1:0];
`else
  assign hi_pat = '0;
  assign lo_pat = '0;
`endif

  seven_seg_decode u_dec_hi (
    .pattern  (hi_pat),
    .nibble_c (hi_nibble),
    .known_c  (hi_known)
  );

  seven_seg_decode u_dec_lo (
    .pattern  (lo_pat),
    .nibble_c (lo_nibble),
    .known_c  (lo_known)
  );

endmodule

// File: tb/tb_seven_seg_capture.sv
// Self-checking bench for seven_seg_capture: directed scenarios plus a
// randomized phase, compared every cycle against a behavioural model.
module tb_seven_seg_capture;

  localparam int unsigned FREQ    = 3;
  localparam int unsigned TIMEOUT = 2 * (FREQ + 1);
`ifdef SEVEN_SEG_DECODE_EN
  localparam bit DEC_EN = 1'b1;
`else
  localparam bit DEC_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [6:0]  segment = '0;
  logic        sig = 1'b0;
  logic [13:0] both7seg;
  logic        pair_valid;
  logic [3:0]  hi_nibble, lo_nibble;
  logic        hi_known, lo_known;
  logic        locked, timeout;

  seven_seg_capture #(.FREQ(FREQ), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .rst        (rst),
    .segment    (segment),
    .sig        (sig),
    .both7seg   (both7seg),
    .pair_valid (pair_valid),
    .hi_nibble  (hi_nibble),
    .lo_nibble  (lo_nibble),
    .hi_known   (hi_known),
    .lo_known   (lo_known),
    .locked     (locked),
    .timeout    (timeout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int pv_seen = 0;
  bit chk_en = 1'b0;

  logic [6:0] pat_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D,
                               7'h7D, 7'h07, 7'h7F, 7'h6F, 7'h77, 7'h7C,
                               7'h39, 7'h5E, 7'h79, 7'h71};

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
    end
  endtask

  // Expected decode of one pattern by table search.
  function automatic logic [4:0] exp_digit(input logic [6:0] p);
    logic [4:0] r;
    r = 5'h00;
    if (DEC_EN) begin
      for (int i = 0; i < 16; i++) begin
        if (pat_tab[i] == p) r = {1'b1, 4'(i)};
      end
    end
    return r;
  endfunction

  // Behavioural model: expect-lo flag, idle-cycle count, captured word.
  logic [13:0] m_word = '0;
  bit m_pv = 0, m_locked = 0, m_to = 0, m_expect_lo = 0;
  int m_idle = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_word = '0; m_pv = 0; m_locked = 0; m_to = 0; m_expect_lo = 0;
      m_idle = 0;
    end else begin
      m_pv = 0;
      if (sig) begin
        m_idle = 0;
        m_to = 0;
        if (!m_expect_lo) begin
          m_word = {segment, m_word[6:0]};
          m_expect_lo = 1;
        end else begin
          m_word = {m_word[13:7], segment};
          m_pv = 1;
          m_locked = 1;
          m_expect_lo = 0;
        end
      end else begin
        if (m_idle < int'(TIMEOUT)) m_idle++;
        if (m_idle == int'(TIMEOUT)) begin
          m_to = 1;
          m_locked = 0;
          m_expect_lo = 0;
        end
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      logic [4:0] eh, el;
      eh = exp_digit(m_word[13:7]);
      el = exp_digit(m_word[6:0]);
      check("both7seg", 32'(both7seg), 32'(m_word));
      check("pair_valid", 32'(pair_valid), 32'(m_pv));
      check("locked", 32'(locked), 32'(m_locked));
      check("timeout", 32'(timeout), 32'(m_to));
      check("hi_digit", 32'({hi_known, hi_nibble}), 32'(eh));
      check("lo_digit", 32'({lo_known, lo_nibble}), 32'(el));
      if (pair_valid === 1'b1) pv_seen++;
    end
  end

  task automatic tick(input logic s, input logic [6:0] seg);
    sig = s;
    segment = seg;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 7'h00);
  endtask

  int base;

  initial begin
    @(negedge clk);
    // Reset with a strobe present: it must be ignored.
    rst = 1'b1;
    tick(1'b1, 7'h06);
    chk_en = 1'b1;
    tick(1'b0, 7'h00);
    check("rst_both7seg", 32'(both7seg), 32'h0);
    check("rst_locked", 32'(locked), 32'h0);
    check("rst_hi_known", 32'(hi_known), 32'h0);
    rst = 1'b0;

    // Basic pair 06 / 5B.
    tick(1'b1, 7'h06);
    check("hi_only_no_pv", 32'(pair_valid), 32'h0);
    tick(1'b1, 7'h5B);
    check("basic_word", 32'(both7seg), 32'h035B);
    check("basic_pv", 32'(pair_valid), 32'h1);
    check("basic_hi_nib", 32'(hi_nibble), DEC_EN ? 32'h1 : 32'h0);
    check("basic_lo_nib", 32'(lo_nibble), DEC_EN ? 32'h2 : 32'h0);
    check("basic_known", 32'({hi_known, lo_known}), DEC_EN ? 32'h3 : 32'h0);
    check("basic_locked", 32'(locked), 32'h1);
    check("pin_model_word", 32'(m_word), 32'h035B);
    tick(1'b0, 7'h00);
    check("basic_pv_drop", 32'(pair_valid), 32'h0);

    // Illegal lo pattern.
    tick(1'b1, 7'h7F);
    tick(1'b1, 7'h00);
    check("illegal_hi", 32'({hi_known, hi_nibble}), DEC_EN ? 32'h18 : 32'h0);
    check("illegal_lo", 32'({lo_known, lo_nibble}), 32'h0);

    // Stale link.
    idle(int'(TIMEOUT) - 1);
    check("pre_timeout", 32'(timeout), 32'h0);
    idle(1);
    check("timeout_set", 32'(timeout), 32'h1);
    check("timeout_unlock", 32'(locked), 32'h0);
    check("timeout_hold", 32'(both7seg), 32'h3F80);
    check("pin_model_to", 32'(m_to), 32'h1);
    idle(3);
    tick(1'b1, 7'h71);
    check("resync_word", 32'(both7seg), 32'h3880);
    check("resync_to_clr", 32'(timeout), 32'h0);
    tick(1'b1, 7'h3F);

    // Strobe coincides with watchdog expiry, in both phases.
    idle(int'(TIMEOUT) - 1);
    tick(1'b1, 7'h3F);
    check("simul_hi_to", 32'(timeout), 32'h0);
    check("simul_hi_word", 32'(both7seg[13:7]), 32'h3F);
    idle(int'(TIMEOUT) - 1);
    tick(1'b1, 7'h06);
    check("simul_lo_to", 32'(timeout), 32'h0);
    check("simul_lo_pv", 32'(pair_valid), 32'h1);
    check("simul_lo_word", 32'(both7seg), 32'h1F86);

    // Reset mid-pair.
    tick(1'b1, 7'h3F);
    rst = 1'b1;
    tick(1'b1, 7'h5B);
    rst = 1'b0;
    base = pv_seen;
    tick(1'b1, 7'h4F);
    tick(1'b1, 7'h66);
    check("midrst_word", 32'(both7seg), 32'h27E6);
    idle(3);
    check("midrst_pv_count", 32'(pv_seen - base), 32'h1);

    // Randomized traffic.
    for (int n = 0; n < 600; n++) begin
      int r;
      logic [6:0] seg;
      r = int'($urandom_range(0, 99));
      seg = ($urandom_range(0, 1) == 0) ? pat_tab[$urandom_range(0, 15)]
                                        : 7'($urandom);
      if (r < 2) begin
        rst = 1'b1;
        tick(1'($urandom_range(0, 1)), seg);
        rst = 1'b0;
      end else if (r < 7) begin
        idle(int'(TIMEOUT) - 2 + int'($urandom_range(0, 3)));
        tick(1'b1, seg);
      end else begin
        tick(($urandom_range(0, 2) == 0), seg);
      end
    end

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seven_seg_capture.md
SEVEN_SEG_CAPTURE -- requirements
Module: seven_seg_capture

Interface
REQ-001 SHALL have parameter FREQ, default 40000, the strobe period of the driving multiplexer in cycles minus one.
REQ-002 SHALL have parameter TIMEOUT, default 2*(FREQ+1), the number of cycles without a strobe after which the link is declared stale.
REQ-003 SHALL have port clk, input, 1, clock.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port segment, input, 7, multiplexed segment bus {g,f,e,d,c,b,a}, active-high.
REQ-006 SHALL have port sig, input, 1, single-cycle strobe marking a new digit on segment.
REQ-007 SHALL have port both7seg, output, 14, reconstructed pair {hi[13:7], lo[6:0]}.
REQ-008 SHALL have port pair_valid, output, 1, one-cycle pulse when a complete hi+lo pair has been captured.
REQ-009 SHALL have port hi_nibble and lo_nibble, output, 4 each, hex values decoded from the captured digits.
REQ-010 SHALL have port hi_known and lo_known, output, 1 each, high when the matching digit is a legal 0-F pattern.
REQ-011 SHALL have port locked, output, 1, high after the first complete pair and until the next timeout.
REQ-012 SHALL have port timeout, output, 1, sticky stale-link flag.

Function
REQ-013 SHALL use a two-state FSM: WAIT_HI, then WAIT_LO; a strobe arriving after reset or timeout is the high digit.
REQ-014 SHALL, on sig=1 in WAIT_HI, register segment into both7seg[13:7] at that clock edge and move to WAIT_LO.
REQ-015 SHALL, on sig=1 in WAIT_LO, register segment into both7seg[6:0], assert pair_valid for exactly the following cycle, set locked, and move to WAIT_HI.
REQ-016 SHALL never pulse pair_valid when a high-digit capture completes.
REQ-017 SHALL keep a watchdog counter, 18 bits minimum, that clears on every strobe and otherwise increments, saturating at TIMEOUT.
REQ-018 SHALL, when the watchdog reaches TIMEOUT, set timeout, clear locked and return the FSM to WAIT_HI; both7seg SHALL hold its last value.
REQ-019 SHALL clear timeout on the next strobe; that strobe is captured as a high digit.
REQ-020 SHALL give the strobe priority when a strobe and the watchdog reaching TIMEOUT occur in the same cycle: no timeout, normal capture.
REQ-021 SHALL update the nibble and known outputs in the same cycle as the matching both7seg field.
REQ-022 SHALL decode with the standard table 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71 (hex, gfedcba).
REQ-023 SHALL, for any other pattern (including blank 00), output nibble 0 and known 0.

Reset
REQ-024 SHALL, while rst=1, set both7seg=0, all nibbles=0, all known flags=0, pair_valid=0, locked=0, timeout=0, watchdog=0 and FSM=WAIT_HI.
REQ-025 SHALL ignore any strobe sampled while rst=1; reset in the middle of a pair discards the partial pair.

Configuration
REQ-026 SHALL, with SEVEN_SEG_DECODE_EN defined, implement REQ-021 to REQ-023.
REQ-027 SHALL, without SEVEN_SEG_DECODE_EN, tie the nibble and known outputs to 0 and keep the port list unchanged; all other behaviour SHALL be identical.

Structure
REQ-028 SHALL place the FSM state enum, segment pattern constants, the FREQ default and the decode function in package seven_seg_pkg.
REQ-029 SHALL implement the pattern decode as combinational sub-module seven_seg_decode, instantiated once per digit.

Verification
REQ-030 SHALL cover a basic pair: after reset, strobe with segment=06, then strobe with segment=5B -> both7seg=0x035B, pair_valid pulses once, hi_nibble=1, lo_nibble=2, both known=1, locked=1.
REQ-031 SHALL cover an illegal pattern: a pair with 7F then 00 -> hi_nibble=8, hi_known=1, lo_nibble=0, lo_known=0.
REQ-032 SHALL cover a stale link: after a pair, no strobe for TIMEOUT cycles -> timeout=1, locked=0; next strobe 71 lands in both7seg[13:7] and clears timeout.
REQ-033 SHALL cover simultaneous events: a strobe in the exact cycle the watchdog reaches TIMEOUT -> timeout stays 0 and capture follows the FSM phase.
REQ-034 SHALL cover reset mid-pair: strobe 3F, assert rst for 1 cycle, then strobe 4F then 66 -> both7seg=0x27E6 and exactly one pair_valid after reset.
REQ-035 SHALL cover the build without the macro: the REQ-030 stimulus gives nibble and known outputs of 0 and the same both7seg and pair_valid as REQ-030.
